// File: rtl/uart_rs232_rx_if.sv
// ----------------------------------------------------------------------------
// uart_rs232_rx_if
//   Register-side bundle of the RS-232 receiver.
//   master : register block; programs RxEn/nBits and reads status/data.
//   slave  : receiver; consumes RxEn/nBits and drives RxData/RxDone/FrameErr/Busy.
//   Signals:
//     RxEn     enable detection of a new start bit
//     nBits    data bits per frame (6, 7 or 8)
//     RxData   last received data, right-justified
//     RxDone   one-cycle frame-complete strobe
//     FrameErr stop bit sampled low on the last frame
//     Busy     frame reception in progress
// ----------------------------------------------------------------------------
interface uart_rs232_rx_if;
    logic       RxEn;
    logic [3:0] nBits;
    logic [7:0] RxData;
    logic       RxDone;
    logic       FrameErr;
    logic       Busy;

    modport master (output RxEn, nBits, input RxData, RxDone, FrameErr, Busy);
    modport slave  (input RxEn, nBits, output RxData, RxDone, FrameErr, Busy);
endinterface

// File: rtl/uart_rs232_rx.sv
// ----------------------------------------------------------------------------
// uart_rs232_rx
//   RS-232 receiver for 6/7/8-bit frames (1 start, no parity, 1 stop, LSB
//   first), oversampling on a shared 16x-baud tick enable.
//   Ports:
//     Clk    system clock
//     Rst_n  asynchronous active-low reset
//     Rx     serial line, asynchronous to Clk, idle high
//     tick   16x baud enable, one Clk wide
//     rif    register-side bundle (slave modport)
// ----------------------------------------------------------------------------
module uart_rs232_rx (
    input  logic            Clk,
    input  logic            Rst_n,
    input  logic            Rx,
    input  logic            tick,
    uart_rs232_rx_if.slave  rif
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t     state;
    logic       rxMeta, rxS, rxD;
    logic [3:0] tickCnt;
    logic [3:0] bitCnt;
    logic [3:0] nb;
    logic [7:0] sh;
    logic [7:0] rxData;
    logic       rxDone, frameErr, busy;
    logic       nbValid, startEdge;

    assign nbValid   = (rif.nBits == 4'd6) || (rif.nBits == 4'd7) || (rif.nBits == 4'd8);
    assign startEdge = rxD & ~rxS;

    // Two-flop synchronizer plus one delayed copy for falling-edge detect.
    // Reset to the idle-high line level so reset release never looks like an edge.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rxMeta <= 1'b1;
            rxS    <= 1'b1;
            rxD    <= 1'b1;
        end else begin
            rxMeta <= Rx;
            rxS    <= rxMeta;
            rxD    <= rxS;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= IDLE;
            tickCnt  <= '0;
            bitCnt   <= '0;
            nb       <= '0;
            sh       <= '0;
            rxData   <= '0;
            rxDone   <= 1'b0;
            frameErr <= 1'b0;
            busy     <= 1'b0;
        end else begin
            rxDone <= 1'b0;
            case (state)
                IDLE: begin
                    // A held-low line (e.g. after a bad stop bit) cannot restart
                    // a frame: an actual high-to-low transition is required.
                    if (rif.RxEn && nbValid && startEdge) begin
                        state   <= START;
                        nb      <= rif.nBits;
                        tickCnt <= '0;
                        busy    <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        if (tickCnt == 4'd7) begin
                            tickCnt <= '0;
                            if (!rxS) begin
                                state  <= DATA;
                                bitCnt <= '0;
                            end else begin
                                // Line back high at mid start bit: a glitch.
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            tickCnt <= tickCnt + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        // Terminal count 15 wraps to 0, which is also the
                        // counter clear on entry to the next state.
                        tickCnt <= tickCnt + 4'd1;
                        if (tickCnt == 4'd15) begin
                            sh     <= {rxS, sh[7:1]};
                            bitCnt <= bitCnt + 4'd1;
                            if (bitCnt + 4'd1 == nb)
                                state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        tickCnt <= tickCnt + 4'd1;
                        if (tickCnt == 4'd15) begin
                            // Short frames sit in the top of sh; shift down.
                            rxData   <= sh >> (4'd8 - nb);
                            frameErr <= ~rxS;
                            rxDone   <= 1'b1;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rif.RxData   = rxData;
    assign rif.RxDone   = rxDone;
    assign rif.FrameErr = frameErr;
    assign rif.Busy     = busy;

endmodule

// File: tb/tb_uart_rs232_rx.sv
module tb_uart_rs232_rx;

    logic Clk = 1'b0;
    logic Rst_n;
    logic Rx;
    logic tick = 1'b0;

    uart_rs232_rx_if rif();

    uart_rs232_rx dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .Rx    (Rx),
        .tick  (tick),
        .rif   (rif)
    );

    always #5 Clk = ~Clk;

    // tick every 10 clocks, plus a running tick count for timestamps
    int          divCnt  = 0;
    int unsigned tickNum = 0;
    always @(posedge Clk) begin
        divCnt <= (divCnt == 9) ? 0 : divCnt + 1;
        tick   <= (divCnt == 9);
        if (tick) tickNum <= tickNum + 1;
    end

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [7:0]  data;
        logic        fe;
        int unsigned tk;
    } done_t;

    done_t doneQ[$];
    done_t expQ[$];
    logic  busySeen;

    // Completion monitor; Busy must already be low in the RxDone cycle
    always @(negedge Clk) begin
        if (rif.Busy === 1'b1) busySeen = 1'b1;
        if (rif.RxDone === 1'b1) begin
            done_t d;
            d.data = rif.RxData;
            d.fe   = rif.FrameErr;
            d.tk   = tickNum;
            doneQ.push_back(d);
            vectors++;
            if (rif.Busy !== 1'b0) begin
                miscompares++;
                $display("FAIL busy_in_done: Busy=%b expected 0", rif.Busy);
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "timeout");
    end

    task automatic waitTick();
        do @(posedge Clk); while (tick !== 1'b1);
        #1;
    endtask

    task automatic waitTicks(input int n);
        repeat (n) waitTick();
    endtask

    task automatic sendBit(input logic b);
        Rx = b;
        waitTicks(16);
    endtask

    task automatic sendFrame(input logic [7:0] d, input int nb, input logic stopB);
        rif.nBits = 4'(nb);
        sendBit(1'b0);
        for (int i = 0; i < nb; i++) sendBit(d[i]);
        sendBit(stopB);
    endtask

    task automatic test_reset();
        Rst_n = 1'b0;
        Rx = 1'b1;
        rif.RxEn = 1'b1;
        rif.nBits = 4'd8;
        repeat (3) @(negedge Clk);
        vectors++; if (rif.RxData !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h want 00", rif.RxData); end
        vectors++; if (rif.RxDone !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", rif.RxDone); end
        vectors++; if (rif.FrameErr !== 1'b0) begin miscompares++; $display("FAIL reset_fe: got %b want 0", rif.FrameErr); end
        vectors++; if (rif.Busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", rif.Busy); end
        Rst_n = 1'b1;
        waitTicks(20);
    endtask

    task automatic test_basic();
        doneQ.delete();
        sendFrame(8'hA5, 8, 1'b1);
        waitTicks(4);
        @(negedge Clk);
        vectors++; if (doneQ.size() !== 1) begin miscompares++; $display("FAIL basic_count: got %0d want 1", doneQ.size()); end
        if (doneQ.size() >= 1) begin
            vectors++; if (doneQ[0].data !== 8'hA5) begin miscompares++; $display("FAIL basic_data: got %h want a5", doneQ[0].data); end
            vectors++; if (doneQ[0].fe !== 1'b0) begin miscompares++; $display("FAIL basic_fe: got %b want 0", doneQ[0].fe); end
        end
        vectors++; if (rif.Busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy: got %b want 0", rif.Busy); end
    endtask

    task automatic test_nbits();
        doneQ.delete();
        sendFrame(8'h5A, 7, 1'b1);
        waitTicks(16);
        sendFrame(8'h2B, 6, 1'b1);
        waitTicks(4);
        vectors++; if (doneQ.size() !== 2) begin miscompares++; $display("FAIL nbits_count: got %0d want 2", doneQ.size()); end
        if (doneQ.size() >= 2) begin
            vectors++; if (doneQ[0].data !== 8'h5A) begin miscompares++; $display("FAIL nbits7_data: got %h want 5a", doneQ[0].data); end
            vectors++; if (doneQ[1].data !== 8'h2B) begin miscompares++; $display("FAIL nbits6_data: got %h want 2b", doneQ[1].data); end
        end
    endtask

    task automatic test_glitch();
        doneQ.delete();
        busySeen = 1'b0;
        Rx = 1'b0;
        waitTicks(4);
        Rx = 1'b1;
        waitTicks(24);
        @(negedge Clk);
        vectors++; if (doneQ.size() !== 0) begin miscompares++; $display("FAIL glitch_done: got %0d strobes want 0", doneQ.size()); end
        vectors++; if (busySeen !== 1'b1) begin miscompares++; $display("FAIL glitch_busy_pulse: got %b want 1", busySeen); end
        vectors++; if (rif.Busy !== 1'b0) begin miscompares++; $display("FAIL glitch_busy_end: got %b want 0", rif.Busy); end
        vectors++; if (rif.RxData !== 8'h2B) begin miscompares++; $display("FAIL glitch_data: got %h want 2b", rif.RxData); end
    endtask

    task automatic test_framing();
        doneQ.delete();
        sendFrame(8'h3C, 8, 1'b0);
        Rx = 1'b0;
        waitTicks(20 * 16);
        vectors++; if (doneQ.size() !== 1) begin miscompares++; $display("FAIL frame_lowhold: got %0d strobes want 1", doneQ.size()); end
        Rx = 1'b1;
        waitTicks(16);
        sendFrame(8'h81, 8, 1'b1);
        waitTicks(4);
        vectors++; if (doneQ.size() !== 2) begin miscompares++; $display("FAIL frame_count: got %0d want 2", doneQ.size()); end
        if (doneQ.size() >= 2) begin
            vectors++; if (doneQ[0].data !== 8'h3C) begin miscompares++; $display("FAIL frame_bad_data: got %h want 3c", doneQ[0].data); end
            vectors++; if (doneQ[0].fe !== 1'b1) begin miscompares++; $display("FAIL frame_bad_fe: got %b want 1", doneQ[0].fe); end
            vectors++; if (doneQ[1].data !== 8'h81) begin miscompares++; $display("FAIL frame_good_data: got %h want 81", doneQ[1].data); end
            vectors++; if (doneQ[1].fe !== 1'b0) begin miscompares++; $display("FAIL frame_good_fe: got %b want 0", doneQ[1].fe); end
        end
    endtask

    task automatic test_back_to_back();
        doneQ.delete();
        sendFrame(8'h00, 8, 1'b1);
        sendFrame(8'hFF, 8, 1'b1);
        waitTicks(4);
        vectors++; if (doneQ.size() !== 2) begin miscompares++; $display("FAIL b2b_count: got %0d want 2", doneQ.size()); end
        if (doneQ.size() >= 2) begin
            vectors++; if (doneQ[0].data !== 8'h00) begin miscompares++; $display("FAIL b2b_data0: got %h want 00", doneQ[0].data); end
            vectors++; if (doneQ[1].data !== 8'hFF) begin miscompares++; $display("FAIL b2b_data1: got %h want ff", doneQ[1].data); end
            vectors++; if (doneQ[1].tk - doneQ[0].tk !== 160) begin miscompares++; $display("FAIL b2b_spacing: got %0d ticks want 160", doneQ[1].tk - doneQ[0].tk); end
        end
    endtask

    task automatic test_rst_mid();
        logic [7:0] d;
        d = 8'h55;
        doneQ.delete();
        rif.nBits = 4'd8;
        sendBit(1'b0);
        for (int i = 0; i < 3; i++) sendBit(d[i]);
        @(negedge Clk);
        Rst_n = 1'b0;
        Rx = 1'b1;
        repeat (2) @(negedge Clk);
        vectors++; if (rif.RxData !== 8'h00) begin miscompares++; $display("FAIL rstmid_data: got %h want 00", rif.RxData); end
        vectors++; if (rif.Busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %b want 0", rif.Busy); end
        vectors++; if (rif.FrameErr !== 1'b0) begin miscompares++; $display("FAIL rstmid_fe: got %b want 0", rif.FrameErr); end
        vectors++; if (rif.RxDone !== 1'b0) begin miscompares++; $display("FAIL rstmid_done: got %b want 0", rif.RxDone); end
        Rst_n = 1'b1;
        waitTicks(16 * 8);
        vectors++; if (doneQ.size() !== 0) begin miscompares++; $display("FAIL rstmid_no55: got %0d strobes want 0", doneQ.size()); end
        sendFrame(8'h96, 8, 1'b1);
        waitTicks(4);
        vectors++; if (doneQ.size() !== 1) begin miscompares++; $display("FAIL rstmid_count: got %0d want 1", doneQ.size()); end
        if (doneQ.size() >= 1) begin
            vectors++; if (doneQ[0].data !== 8'h96) begin miscompares++; $display("FAIL rstmid_after: got %h want 96", doneQ[0].data); end
        end
    endtask

    // Random frames; the model is frame-level: value modulo 2^nb, error = stop bit low.
    // RxEn and nBits are scrambled after the start bit to show they are latched.
    task automatic test_random();
        doneQ.delete();
        expQ.delete();
        for (int f = 0; f < 10; f++) begin
            logic [7:0] d;
            int         nb, gap;
            logic       stopB, en;
            done_t      e;
            d     = 8'($urandom);
            nb    = 6 + int'($urandom_range(0, 2));
            stopB = ($urandom_range(0, 3) != 0);
            en    = ($urandom_range(0, 4) != 0);
            gap   = int'($urandom_range(0, 2));
            if (!stopB && gap == 0) gap = 1;
            rif.RxEn  = en;
            rif.nBits = 4'(nb);
            sendBit(1'b0);
            rif.nBits = 4'($urandom);
            if (en) rif.RxEn = 1'($urandom);
            for (int i = 0; i < nb; i++) sendBit(d[i]);
            sendBit(stopB);
            if (en) begin
                e.data = 8'(int'(d) % (1 << nb));
                e.fe   = ~stopB;
                e.tk   = 0;
                expQ.push_back(e);
            end
            Rx = 1'b1;
            waitTicks(16 * gap);
        end
        rif.RxEn = 1'b1;
        waitTicks(4);
        vectors++; if (doneQ.size() !== expQ.size()) begin miscompares++; $display("FAIL rand_count: got %0d want %0d", doneQ.size(), expQ.size()); end
        for (int i = 0; i < expQ.size() && i < doneQ.size(); i++) begin
            vectors++;
            if (doneQ[i].data !== expQ[i].data || doneQ[i].fe !== expQ[i].fe) begin
                miscompares++;
                $display("FAIL rand_frame%0d: got data=%h fe=%b want data=%h fe=%b",
                         i, doneQ[i].data, doneQ[i].fe, expQ[i].data, expQ[i].fe);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_nbits();
        test_glitch();
        test_framing();
        test_back_to_back();
        test_rst_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
